// File: rtl/trigger_unit_multi.sv
// Multi-input ADC trigger: per-channel enable/polarity combined by OR or AND, followed by an
// offset delay and a segmented capture sequencer (retriggered or timer-spaced segments).
module trigger_unit_multi #(
  parameter int NUM_TRIG = 4,
  parameter int OFFSET_W = 32,
  parameter int SEG_W    = 16,
  parameter int LEN_W    = 32
) (
  input  logic                adc_clk,
  input  logic                reset_n,
  input  logic [NUM_TRIG-1:0] trigger_i,
  input  logic [NUM_TRIG-1:0] trig_enable_i,
  input  logic [NUM_TRIG-1:0] trig_level_i,
  input  logic                trig_combine_i,
  input  logic                trigger_wait_i,
  input  logic                trigger_now_i,
  input  logic                arm_i,
  input  logic                armed_and_ready,
  input  logic [OFFSET_W-1:0] trigger_offset_i,
  input  logic [SEG_W-1:0]    num_segments_i,
  input  logic                seg_retrigger_i,
  input  logic [OFFSET_W-1:0] segment_cycles_i,
  input  logic                capture_done_i,
  output logic                arm_o,
  output logic                capture_active_o,
  output logic                capture_go_o,
  output logic [SEG_W-1:0]    seg_count_o,
  output logic [LEN_W-1:0]    trigger_length_o,
  output logic [NUM_TRIG-1:0] trig_status_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_ARMING, S_ARMED, S_TRIG, S_GO,
    S_WAIT_LOW, S_WAIT_HIT, S_SEG_TIMER, S_WAIT_DONE, S_DONE
  } state_t;

  state_t              state;
  logic [NUM_TRIG-1:0] match;
  logic                hit;
  logic [2:0]          now_sync;
  logic                now_pulse;
  logic                arm_q;
  logic                arm_rise;
  logic                abort;
  logic [OFFSET_W-1:0] cnt;
  logic [OFFSET_W-1:0] seg_period;
  logic [SEG_W-1:0]    seg_target;

  assign match = ~(trigger_i ^ trig_level_i);
  // AND mode needs at least one enabled channel, otherwise an empty mask would always hit
  assign hit = trig_combine_i ? ((&(~trig_enable_i | match)) & (|trig_enable_i))
                              : (|(trig_enable_i & match));

  assign now_pulse  = now_sync[1] & ~now_sync[2];
  assign arm_rise   = arm_i & ~arm_q;
  assign abort      = (state != S_IDLE) && (state != S_DONE) && (capture_done_i || !arm_i);
  assign seg_period = (segment_cycles_i == '0) ? OFFSET_W'(1) : segment_cycles_i;
  assign seg_target = (num_segments_i == '0) ? SEG_W'(1) : num_segments_i;

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      now_sync <= '0;
      arm_q    <= 1'b0;
    end else begin
      now_sync <= {now_sync[1:0], trigger_now_i};
      arm_q    <= arm_i;
    end
  end

  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      trigger_length_o <= '0;
    end else if (arm_rise) begin
      trigger_length_o <= '0;
    end else if (hit && (trigger_length_o != '1)) begin
      trigger_length_o <= trigger_length_o + LEN_W'(1);
    end
  end

  // cnt counts offset cycles in TRIG and edges since the last go in GO/SEG_TIMER
  always_ff @(posedge adc_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      arm_o            <= 1'b0;
      capture_active_o <= 1'b0;
      capture_go_o     <= 1'b0;
      seg_count_o      <= '0;
      trig_status_o    <= '0;
      cnt              <= '0;
    end else begin
      capture_go_o <= 1'b0;
      if (abort) begin
        arm_o            <= 1'b0;
        capture_active_o <= 1'b0;
        state            <= arm_i ? S_DONE : S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm_rise) begin
              state       <= S_ARMING;
              arm_o       <= 1'b1;
              seg_count_o <= '0;
            end
          end
          S_ARMING: begin
            if (now_pulse) begin
              state            <= S_TRIG;
              cnt              <= '0;
              arm_o            <= 1'b0;
              capture_active_o <= 1'b1;
              trig_status_o    <= match;
            end else if (armed_and_ready && (!hit || !trigger_wait_i)) begin
              state <= S_ARMED;
            end
          end
          S_ARMED: begin
            if (hit || now_pulse) begin
              state            <= S_TRIG;
              cnt              <= '0;
              arm_o            <= 1'b0;
              capture_active_o <= 1'b1;
              trig_status_o    <= match;
            end
          end
          S_TRIG: begin
            if (cnt >= trigger_offset_i) begin
              state        <= S_GO;
              capture_go_o <= 1'b1;
              seg_count_o  <= seg_count_o + SEG_W'(1);
              cnt          <= '0;
            end else begin
              cnt <= cnt + OFFSET_W'(1);
            end
          end
          S_GO, S_SEG_TIMER: begin
            if ((state == S_GO) && (seg_count_o >= seg_target)) begin
              state <= S_WAIT_DONE;
            end else if ((state == S_GO) && seg_retrigger_i) begin
              state <= S_WAIT_LOW;
            end else if (cnt >= seg_period - OFFSET_W'(1)) begin
              state        <= S_GO;
              capture_go_o <= 1'b1;
              seg_count_o  <= seg_count_o + SEG_W'(1);
              cnt          <= '0;
            end else begin
              state <= S_SEG_TIMER;
              cnt   <= cnt + OFFSET_W'(1);
            end
          end
          S_WAIT_LOW: begin
            if (!hit) state <= S_WAIT_HIT;
          end
          S_WAIT_HIT: begin
            if (hit || now_pulse) begin
              state <= S_TRIG;
              cnt   <= '0;
            end
          end
          S_WAIT_DONE: state <= S_WAIT_DONE;
          S_DONE: begin
            if (!arm_i) state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trigger_unit_multi.sv
// Directed bench for trigger_unit_multi: a table of hit-logic vectors plus hand-written
// sequences for offset timing, segmenting, abort, reset and length saturation.
module tb_trigger_unit_multi;

  logic        adc_clk = 1'b0;
  logic        reset_n;
  logic [3:0]  trigger_i;
  logic [3:0]  trig_enable_i;
  logic [3:0]  trig_level_i;
  logic        trig_combine_i;
  logic        trigger_wait_i;
  logic        trigger_now_i;
  logic        arm_i;
  logic        armed_and_ready;
  logic [31:0] trigger_offset_i;
  logic [15:0] num_segments_i;
  logic        seg_retrigger_i;
  logic [31:0] segment_cycles_i;
  logic        capture_done_i;
  logic        arm_o;
  logic        capture_active_o;
  logic        capture_go_o;
  logic [15:0] seg_count_o;
  logic [4:0]  trigger_length_o;
  logic [3:0]  trig_status_o;

  int n_compared   = 0;
  int n_mismatched = 0;
  int go_edges[$];

  typedef struct {
    logic       combine;
    logic [3:0] en;
    logic [3:0] lvl;
    logic [3:0] trig;
    logic       exp_hit;
    logic [3:0] exp_status;
  } vec_t;

  vec_t vecs[10];

  trigger_unit_multi #(.LEN_W(5)) dut (
    .adc_clk          (adc_clk),
    .reset_n          (reset_n),
    .trigger_i        (trigger_i),
    .trig_enable_i    (trig_enable_i),
    .trig_level_i     (trig_level_i),
    .trig_combine_i   (trig_combine_i),
    .trigger_wait_i   (trigger_wait_i),
    .trigger_now_i    (trigger_now_i),
    .arm_i            (arm_i),
    .armed_and_ready  (armed_and_ready),
    .trigger_offset_i (trigger_offset_i),
    .num_segments_i   (num_segments_i),
    .seg_retrigger_i  (seg_retrigger_i),
    .segment_cycles_i (segment_cycles_i),
    .capture_done_i   (capture_done_i),
    .arm_o            (arm_o),
    .capture_active_o (capture_active_o),
    .capture_go_o     (capture_go_o),
    .seg_count_o      (seg_count_o),
    .trigger_length_o (trigger_length_o),
    .trig_status_o    (trig_status_o)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge adc_clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic combine, input logic [3:0] en, input logic [3:0] lvl,
                               input logic [31:0] offset, input logic [15:0] nseg,
                               input logic retrig, input logic [31:0] spacing);
    trig_combine_i   = combine;
    trig_enable_i    = en;
    trig_level_i     = lvl;
    trigger_offset_i = offset;
    num_segments_i   = nseg;
    seg_retrigger_i  = retrig;
    segment_cycles_i = spacing;
  endtask

  // drop arm (aborting anything in flight), then raise it; leaves the unit in ARMED
  task automatic armUnit();
    arm_i = 1'b0;
    step(2);
    arm_i = 1'b1;
    step(2);
  endtask

  task automatic runPulse(input logic [3:0] pattern, input int len, input int period,
                          input int count, input int cycles);
    go_edges.delete();
    for (int c = 0; c < cycles; c++) begin
      trigger_i = ((c < period * count) && ((c % period) < len)) ? pattern : 4'b0000;
      step(1);
      if (capture_go_o) go_edges.push_back(c);
    end
    trigger_i = 4'b0000;
  endtask

  task automatic checkGoList(input string name, input int n, input int exp_e[4]);
    int act;
    checkOutput({name, "_go_count"}, go_edges.size(), n);
    for (int i = 0; i < n; i++) begin
      act = (i < go_edges.size()) ? go_edges[i] : -1;
      checkOutput($sformatf("%s_go%0d_edge", name, i), act, exp_e[i]);
    end
  endtask

  task automatic runTimed(input logic [15:0] nseg, input logic [31:0] spacing);
    applyStimulus(1'b0, 4'b0001, 4'b1111, 32'd0, nseg, 1'b0, spacing);
    armUnit();
    runPulse(4'b0001, 1, 100, 1, 50);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 4'b0010, 4'b1111, 4'b0010, 1'b1, 4'b0010};
    vecs[1] = '{1'b0, 4'b0010, 4'b1111, 4'b1101, 1'b0, 4'b0000};
    vecs[2] = '{1'b0, 4'b1100, 4'b0011, 4'b0000, 1'b1, 4'b1100};
    vecs[3] = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    vecs[4] = '{1'b1, 4'b0101, 4'b1111, 4'b0001, 1'b0, 4'b0000};
    vecs[5] = '{1'b1, 4'b0101, 4'b1111, 4'b0101, 1'b1, 4'b0101};
    vecs[6] = '{1'b1, 4'b0000, 4'b1111, 4'b1111, 1'b0, 4'b0000};
    vecs[7] = '{1'b1, 4'b1001, 4'b1000, 4'b1000, 1'b1, 4'b1111};
    vecs[8] = '{1'b1, 4'b1111, 4'b1010, 4'b1011, 1'b0, 4'b0000};
    vecs[9] = '{1'b0, 4'b1000, 4'b0111, 4'b1111, 1'b0, 4'b0000};

    reset_n         = 1'b0;
    trigger_i       = 4'b0000;
    trigger_wait_i  = 1'b0;
    trigger_now_i   = 1'b0;
    arm_i           = 1'b0;
    armed_and_ready = 1'b1;
    capture_done_i  = 1'b0;
    applyStimulus(1'b0, 4'b0000, 4'b0000, 32'd0, 16'd1, 1'b0, 32'd1);
    step(3);
    checkOutput("reset_arm_o", arm_o, 0);
    checkOutput("reset_active", capture_active_o, 0);
    checkOutput("reset_go", capture_go_o, 0);
    checkOutput("reset_seg_count", seg_count_o, 0);
    checkOutput("reset_length", trigger_length_o, 0);
    checkOutput("reset_status", trig_status_o, 0);
    reset_n = 1'b1;
    step(2);

    // hit-logic table: pattern present through arming, first ARMED edge must trigger or not
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].combine, vecs[v].en, vecs[v].lvl, 32'd100, 16'd1, 1'b0, 32'd1);
      trigger_i = vecs[v].trig;
      armUnit();
      step(1);
      checkOutput($sformatf("vec%0d_active", v), capture_active_o, vecs[v].exp_hit);
      if (vecs[v].exp_hit)
        checkOutput($sformatf("vec%0d_status", v), trig_status_o, vecs[v].exp_status);
    end
    trigger_i = 4'b0000;

    // OR mode with offset 5: hit at edge 0 gives a single go at edge 6
    applyStimulus(1'b0, 4'b0010, 4'b1111, 32'd5, 16'd1, 1'b0, 32'd1);
    armUnit();
    checkOutput("t1_arm_o_armed", arm_o, 1);
    runPulse(4'b0010, 1, 20, 1, 12);
    checkGoList("t1", 1, '{6, 0, 0, 0});
    checkOutput("t1_active", capture_active_o, 1);
    checkOutput("t1_arm_o", arm_o, 0);
    checkOutput("t1_status", trig_status_o, 4'b0010);
    checkOutput("t1_seg_count", seg_count_o, 1);

    // AND mode: one enabled channel alone must not trigger, both must
    applyStimulus(1'b1, 4'b0101, 4'b1111, 32'd0, 16'd1, 1'b0, 32'd1);
    armUnit();
    runPulse(4'b0001, 5, 50, 1, 8);
    checkGoList("t2_partial", 0, '{0, 0, 0, 0});
    checkOutput("t2_partial_active", capture_active_o, 0);
    runPulse(4'b0101, 1, 50, 1, 5);
    checkGoList("t2_full", 1, '{1, 0, 0, 0});

    // empty enable mask: only the synchronised forced trigger works
    applyStimulus(1'b1, 4'b0000, 4'b1111, 32'd0, 16'd1, 1'b0, 32'd1);
    armUnit();
    trigger_i = 4'b1111;
    step(3);
    checkOutput("t2_now_no_hit", capture_active_o, 0);
    trigger_now_i = 1'b1;
    go_edges.delete();
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (capture_go_o) go_edges.push_back(c);
    end
    checkGoList("t2_now", 1, '{3, 0, 0, 0});
    trigger_now_i = 1'b0;
    trigger_i     = 4'b0000;

    // trigger_wait: hit high at arm holds ARMING until it drops for a cycle
    applyStimulus(1'b0, 4'b0001, 4'b1111, 32'd0, 16'd1, 1'b0, 32'd1);
    trigger_wait_i = 1'b1;
    trigger_i      = 4'b0001;
    arm_i = 1'b0;
    step(2);
    arm_i = 1'b1;
    step(4);
    checkOutput("t3_wait_arm_o", arm_o, 1);
    checkOutput("t3_wait_active", capture_active_o, 0);
    trigger_i = 4'b0000;
    step(1);
    checkOutput("t3_low_active", capture_active_o, 0);
    trigger_i = 4'b0001;
    step(1);
    checkOutput("t3_trig_active", capture_active_o, 1);
    checkOutput("t3_trig_arm_o", arm_o, 0);
    trigger_i = 4'b0000;
    step(1);
    checkOutput("t3_go", capture_go_o, 1);
    trigger_wait_i = 1'b0;

    // retrigger mode: each of three pulses gives a go three edges later
    applyStimulus(1'b0, 4'b0001, 4'b1111, 32'd2, 16'd3, 1'b1, 32'd1);
    armUnit();
    runPulse(4'b0001, 1, 10, 3, 40);
    checkGoList("t4_pulses", 3, '{3, 13, 23, 0});
    checkOutput("t4_seg_count", seg_count_o, 3);
    checkOutput("t4_active", capture_active_o, 1);
    armUnit();
    runPulse(4'b0001, 40, 40, 1, 40);
    checkGoList("t4_held", 1, '{3, 0, 0, 0});
    checkOutput("t4_held_seg_count", seg_count_o, 1);

    // timed segments, then capture_done ends the capture
    runTimed(16'd4, 32'd10);
    checkGoList("t5_timed", 4, '{1, 11, 21, 31});
    checkOutput("t5_seg_count", seg_count_o, 4);
    checkOutput("t5_active_wait_done", capture_active_o, 1);
    capture_done_i = 1'b1;
    step(1);
    capture_done_i = 1'b0;
    checkOutput("t5_done_active", capture_active_o, 0);
    step(3);
    checkOutput("t5_done_seg_count", seg_count_o, 4);
    checkOutput("t5_done_arm_o", arm_o, 0);

    runTimed(16'd0, 32'd5);
    checkGoList("t5_nseg0", 1, '{1, 0, 0, 0});
    runTimed(16'd3, 32'd0);
    checkGoList("t5_spacing0", 3, '{1, 2, 3, 0});

    // abort on the very edge the go would fire: abort wins
    applyStimulus(1'b0, 4'b0001, 4'b1111, 32'd2, 16'd1, 1'b0, 32'd1);
    armUnit();
    trigger_i = 4'b0001;
    step(1);
    trigger_i = 4'b0000;
    checkOutput("t6_abort_active_before", capture_active_o, 1);
    step(2);
    arm_i = 1'b0;
    step(1);
    checkOutput("t6_abort_go", capture_go_o, 0);
    checkOutput("t6_abort_active", capture_active_o, 0);
    go_edges.delete();
    for (int c = 0; c < 10; c++) begin
      step(1);
      if (capture_go_o) go_edges.push_back(c);
    end
    checkGoList("t6_abort_after", 0, '{0, 0, 0, 0});

    // length counts hit cycles, then asynchronous reset clears everything mid-capture
    applyStimulus(1'b0, 4'b0001, 4'b1111, 32'd50, 16'd1, 1'b0, 32'd1);
    armUnit();
    trigger_i = 4'b0001;
    step(4);
    trigger_i = 4'b0000;
    step(1);
    checkOutput("t6_length4", trigger_length_o, 4);
    #3;
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_active", capture_active_o, 0);
    checkOutput("t6_rst_status", trig_status_o, 0);
    checkOutput("t6_rst_length", trigger_length_o, 0);
    checkOutput("t6_rst_seg_count", seg_count_o, 0);
    checkOutput("t6_rst_arm_o", arm_o, 0);
    step(2);
    reset_n = 1'b1;
    step(1);

    // saturation at 2^LEN_W-1 and clear on the next arm
    armUnit();
    checkOutput("t6_len_after_arm", trigger_length_o, 0);
    trigger_i = 4'b0001;
    step(40);
    checkOutput("t6_len_saturated", trigger_length_o, 31);
    trigger_i = 4'b0000;
    armUnit();
    checkOutput("t6_len_cleared", trigger_length_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
